lm_sm_seq: RTL and testbench
============================

# lm_sm_seq

Load-multiple/store-multiple sequencer for the register-read stage of the pipelined core. It consumes LM/SM instructions held in the ID/RR pipeline register and expands each one into one memory micro-op per set bit of the 8-bit register list. While it expands, it stalls the fetch/decode front end, and it holds its state under downstream stall or flush.

## Interface
- DATA_W, 16: data and address width
- LIST_W, 8: register-list width; equals the register count
- REG_W, 3: register index width, log2(LIST_W)

Ports (one clock domain; `rst` is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-high reset
- valid_rr  in  1  ID/RR register holds a valid instruction
- is_lm_rr, is_sm_rr  in  1 each  decoded LM/SM; never both high
- list_rr  in  LIST_W  `instr_imm9_rr[7:0]`; bit i selects register Ri
- base_addr  in  DATA_W  Ra value read from the register file this cycle
- stall_in  in  1  downstream hazard stall; freeze
- flush  in  1  branch/redirect flush from a later stage
- stall_up  out  1  hold IF/ID and ID/RR (combinational)
- uop_valid  out  1  micro-op valid (registered)
- uop_load, uop_store  out  1 each  micro-op type (registered)
- uop_reg  out  REG_W  register to load or store (registered)
- uop_addr  out  DATA_W  memory address (registered)
- uop_last  out  1  final micro-op of the instruction (registered)
- busy  out  1  state == SEQ

## Operation
- States: IDLE and SEQ. Internal registers: `rem` (LIST_W), `base` (DATA_W), `cnt` (REG_W+1), `typ`.
- Accept condition: IDLE & valid_rr & (is_lm_rr | is_sm_rr) & !stall_in & !flush.
- On accept with list_rr != 0:
  - Capture base_addr and the type.
  - Issue uop0 at the edge: lowest set bit index, addr = base_addr.
  - Set rem = list_rr with its lowest bit cleared, and cnt = 1.
  - Next state is SEQ if rem != 0, otherwise stay IDLE with uop_last = 1.
- On accept with list_rr == 0: no micro-op issued, no stall; the instruction retires as a NOP (see Configuration).
- In SEQ with !stall_in:
  - Issue the lowest set bit of rem, with uop_addr = base + cnt (mod 2^DATA_W).
  - Clear that bit and increment cnt.
  - When the issued bit was the last set bit in rem: uop_last = 1 and next state is IDLE.
- In SEQ with stall_in: state, rem, cnt and all uop_* outputs hold.
- uop_valid deasserts on the cycle after an issue unless another uop is issued at that edge.
- Address spacing is compacted: consecutive transferred registers use consecutive addresses regardless of gaps in the list.
- For LM with Ra in the list, the original Ra value is used for every address, because base is captured at accept.
- stall_up = (accept & popcount(list_rr) > 1) | (SEQ & (popcount(rem) > 1 | stall_in)). It is forced to 0 when flush = 1.
- Flush has priority over everything except reset. At the edge it sets state = IDLE, rem = 0, uop_valid = 0 and uop_last = 0.
- Reset: state IDLE; rem, base, cnt = 0; all uop_* outputs = 0; busy = 0; stall_up = 0.

## Timing
- Latency: uop0 appears 1 cycle after the accept cycle. An N-bit list with no stalls produces N consecutive uop_valid cycles.
- stall_up is high for N-1 cycles. It falls in the cycle that issues the final uop, so ID/RR advances at the same edge that the last uop registers. The same instruction is therefore never re-accepted.
- A flush in the same cycle as accept wins: nothing is issued.
- Asserting rst mid-sequence aborts the sequence immediately. Outputs go to their reset values without waiting for a clock edge.

## Configuration
- LMSM_ZERO_LIST_TRAP_EN defined:
  - Adds output port illegal_list (1 bit, registered, reset 0).
  - It pulses for 1 cycle after an accept with list_rr == 0.
  - No micro-op is issued.
- Undefined: the port is absent and an empty list is a silent NOP.

## Structure
- Shared package holds:
  - The state typedef (IDLE, SEQ).
  - The LIST_W/REG_W constants.
  - The micro-op type encoding.
- One sub-module is natural: lsb_pri_enc. It is a combinational lowest-set-bit encoder producing index, found and one-hot, and it is shared by the accept path and the SEQ path.
- popcount>1 is derived as (v & (v-1)) != 0.

## Test plan
- LM, list 8'b1010_0100, base 0x0100, no stalls -> uops R2@0x0100, R5@0x0101, R7@0x0102 on 3 consecutive cycles; uop_last on R7 only; stall_up high for 2 cycles.
- SM, list 8'b0000_1000 -> single uop R3 store @base, uop_last = 1, stall_up never asserted, busy never asserted.
- LM, list 0xFF, base 0xFFFE, stall_in high for 2 cycles after the second uop -> R0@0xFFFE, R1@0xFFFF (outputs frozen for 2 cycles), R2@0x0000 … R7@0x0005 (wrap-around).
- SM, list 0x0F, flush asserted during the second uop's cycle -> third and later uops suppressed, state IDLE, stall_up = 0 the same cycle.
- LM, list 0x00 -> no uop, no stall. With LMSM_ZERO_LIST_TRAP_EN: illegal_list high for exactly 1 cycle.
- rst asserted asynchronously mid-SEQ (list 0xF0) -> uop_valid, busy and stall_up go to 0 before the next edge. After release, a new LM with list 0x01 is processed normally.

Source files
------------

// File: rtl/lm_sm_seq_pkg.sv
// Shared types and constants for the LM/SM sequencer.
// Holds the state encoding, list/register widths and micro-op type encoding.
package lm_sm_seq_pkg;

    localparam int DATA_W = 16;
    localparam int LIST_W = 8;
    localparam int REG_W  = 3;
    localparam int CNT_W  = REG_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_e;

    typedef enum logic {
        UOP_LOAD  = 1'b0,
        UOP_STORE = 1'b1
    } uop_typ_e;

    // popcount(v) > 1 without an adder tree
    function automatic logic more_than_one(input logic [LIST_W-1:0] v);
        return (v & (v - LIST_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/lm_sm_seq_if.sv
// Bundle between the ID/RR stage and the LM/SM sequencer.
// master: pipeline side (drives instruction/stall/flush); slave: sequencer.
// illegal_list exists only when LMSM_ZERO_LIST_TRAP_EN is defined.
interface lm_sm_seq_if;
    import lm_sm_seq_pkg::*;

    logic              valid_rr;
    logic              is_lm_rr;
    logic              is_sm_rr;
    logic [LIST_W-1:0] list_rr;
    logic [DATA_W-1:0] base_addr;
    logic              stall_in;
    logic              flush;
    logic              stall_up;
    logic              uop_valid;
    logic              uop_load;
    logic              uop_store;
    logic [REG_W-1:0]  uop_reg;
    logic [DATA_W-1:0] uop_addr;
    logic              uop_last;
    logic              busy;
`ifdef LMSM_ZERO_LIST_TRAP_EN
    logic              illegal_list;
`endif

    modport master (
`ifdef LMSM_ZERO_LIST_TRAP_EN
        input  illegal_list,
`endif
        output valid_rr, is_lm_rr, is_sm_rr, list_rr, base_addr,
        output stall_in, flush,
        input  stall_up, uop_valid, uop_load, uop_store,
        input  uop_reg, uop_addr, uop_last, busy
    );

    modport slave (
`ifdef LMSM_ZERO_LIST_TRAP_EN
        output illegal_list,
`endif
        input  valid_rr, is_lm_rr, is_sm_rr, list_rr, base_addr,
        input  stall_in, flush,
        output stall_up, uop_valid, uop_load, uop_store,
        output uop_reg, uop_addr, uop_last, busy
    );

endinterface

// File: rtl/lm_sm_seq_lsb_pri_enc.sv
// Lowest-set-bit encoder: index, found flag and one-hot of the lowest 1.
// Ports: v (in), idx/found/onehot (out); purely combinational.
module lsb_pri_enc
    import lm_sm_seq_pkg::*;
#(
    parameter int W  = LIST_W,
    parameter int IW = REG_W
) (
    input  logic [W-1:0]  v,
    output logic [IW-1:0] idx,
    output logic          found,
    output logic [W-1:0]  onehot
);

    assign found  = |v;
    assign onehot = v & (~v + W'(1));

    // scan downward so the lowest set bit is written last
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/lm_sm_seq.sv
// LM/SM sequencer: expands a register list into one memory uop per set bit.
// Ports: clk, rst (async, active-high), bus (lm_sm_seq_if.slave).
// Optional LMSM_ZERO_LIST_TRAP_EN adds bus.illegal_list for empty lists.
module lm_sm_seq
    import lm_sm_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    lm_sm_seq_if.slave bus
);

    state_e            state;
    uop_typ_e          typ;
    uop_typ_e          iss_typ;
    logic [LIST_W-1:0] rem;
    logic [DATA_W-1:0] base;
    logic [CNT_W-1:0]  cnt;

    logic [LIST_W-1:0] enc_in;
    logic [LIST_W-1:0] enc_oh;
    logic [LIST_W-1:0] enc_rest;
    logic [REG_W-1:0]  enc_idx;
    logic              enc_found;
    logic              is_seq;
    logic              accept;
    logic              multi;
    logic              issue;
    logic [DATA_W-1:0] iss_addr;

    logic              uop_valid_q;
    logic              uop_load_q;
    logic              uop_store_q;
    logic              uop_last_q;
    logic [REG_W-1:0]  uop_reg_q;
    logic [DATA_W-1:0] uop_addr_q;

    assign is_seq = (state == SEQ);

    // one encoder serves both the fresh list and the remaining list
    assign enc_in = is_seq ? rem : bus.list_rr;

    lsb_pri_enc #(
        .W  (LIST_W),
        .IW (REG_W)
    ) u_enc (
        .v      (enc_in),
        .idx    (enc_idx),
        .found  (enc_found),
        .onehot (enc_oh)
    );

    assign enc_rest = enc_in & ~enc_oh;
    assign multi    = more_than_one(enc_in);

    assign accept = !rst && !is_seq && bus.valid_rr
                 && (bus.is_lm_rr || bus.is_sm_rr)
                 && !bus.stall_in && !bus.flush;

    assign issue = (accept && enc_found)
                || (is_seq && !bus.stall_in);

    assign iss_typ = is_seq ? typ
                   : (bus.is_sm_rr ? UOP_STORE : UOP_LOAD);

    // addresses are compacted: k-th transfer goes to base + k
    assign iss_addr = is_seq ? base + DATA_W'(cnt)
                    : bus.base_addr;

    // rst gate keeps stall_up low while reset is held with a valid ID/RR
    assign bus.stall_up = !rst && !bus.flush
        && ((accept && multi) || (is_seq && (multi || bus.stall_in)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            typ         <= UOP_LOAD;
            rem         <= '0;
            base        <= '0;
            cnt         <= '0;
            uop_valid_q <= 1'b0;
            uop_load_q  <= 1'b0;
            uop_store_q <= 1'b0;
            uop_last_q  <= 1'b0;
            uop_reg_q   <= '0;
            uop_addr_q  <= '0;
        end else if (bus.flush) begin
            state       <= IDLE;
            rem         <= '0;
            uop_valid_q <= 1'b0;
            uop_last_q  <= 1'b0;
        end else if (issue) begin
            state       <= (enc_rest != '0) ? SEQ : IDLE;
            typ         <= iss_typ;
            rem         <= enc_rest;
            cnt         <= is_seq ? cnt + CNT_W'(1) : CNT_W'(1);
            if (!is_seq) base <= bus.base_addr;
            uop_valid_q <= 1'b1;
            uop_load_q  <= (iss_typ == UOP_LOAD);
            uop_store_q <= (iss_typ == UOP_STORE);
            uop_last_q  <= (enc_rest == '0);
            uop_reg_q   <= enc_idx;
            uop_addr_q  <= iss_addr;
        end else if (!is_seq) begin
            uop_valid_q <= 1'b0;
            uop_last_q  <= 1'b0;
        end
    end

`ifdef LMSM_ZERO_LIST_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !enc_found;
        end
    end

    assign bus.illegal_list = illegal_q;
`endif

    assign bus.uop_valid = uop_valid_q;
    assign bus.uop_load  = uop_load_q;
    assign bus.uop_store = uop_store_q;
    assign bus.uop_last  = uop_last_q;
    assign bus.uop_reg   = uop_reg_q;
    assign bus.uop_addr  = uop_addr_q;
    assign bus.busy      = is_seq;

endmodule

// File: tb/tb_lm_sm_seq.sv
// Self-checking bench for lm_sm_seq: directed cases plus random lists.
// Expected uops come from a list-walk model of the instruction semantics.
module tb_lm_sm_seq;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    lm_sm_seq_if bus ();

    lm_sm_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.valid_rr  = 1'b0;
        bus.is_lm_rr  = 1'b0;
        bus.is_sm_rr  = 1'b0;
        bus.list_rr   = '0;
        bus.base_addr = '0;
        bus.stall_in  = 1'b0;
        bus.flush     = 1'b0;
    endtask

    // Called at posedge+1. stall_at/flush_at: number of uops already
    // visible on the outputs when stall_in / flush is raised.
    task automatic run(input bit lm, input logic [7:0] list,
                       input logic [15:0] base, input int stall_at,
                       input int stall_len, input int flush_at);
        int          regs[$];
        int          n;
        int          issued;
        int          stl;
        bit          stall;
        bit          fl;
        logic [15:0] ea;

        for (int i = 0; i < 8; i++) if (list[i]) regs.push_back(i);
        n = regs.size();

        bus.valid_rr  = 1'b1;
        bus.is_lm_rr  = lm;
        bus.is_sm_rr  = !lm;
        bus.list_rr   = list;
        bus.base_addr = base;
        bus.stall_in  = 1'b0;
        bus.flush     = (flush_at == 0);
        @(negedge clk);
        chk("acc_stall_up", 32'(bus.stall_up),
            32'(n > 1 && flush_at != 0));
        chk("acc_busy", 32'(bus.busy), 0);
        @(posedge clk); #1;

        if (n == 0 || flush_at == 0) begin
            chk("none_valid", 32'(bus.uop_valid), 0);
            chk("none_busy", 32'(bus.busy), 0);
`ifdef LMSM_ZERO_LIST_TRAP_EN
            chk("illegal", 32'(bus.illegal_list),
                32'(n == 0 && flush_at != 0));
`endif
        end else begin
            issued = 1;
            stl    = 0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                ea = base + 16'(issued - 1);
                chk("uop_valid", 32'(bus.uop_valid), 1);
                chk("uop_reg", 32'(bus.uop_reg), 32'(regs[issued-1]));
                chk("uop_addr", 32'(bus.uop_addr), 32'(ea));
                chk("uop_last", 32'(bus.uop_last), 32'(issued == n));
                chk("uop_load", 32'(bus.uop_load), 32'(lm));
                chk("uop_store", 32'(bus.uop_store), 32'(!lm));
                chk("busy", 32'(bus.busy), 32'(issued < n));
                if (issued == n) break;
                stall = (issued == stall_at) && (stl < stall_len);
                fl    = (issued == flush_at);
                bus.stall_in = stall;
                bus.flush    = fl;
                @(negedge clk);
                chk("seq_stall_up", 32'(bus.stall_up),
                    32'(!fl && (stall || (n - issued) > 1)));
                @(posedge clk); #1;
                if (fl) begin
                    chk("flush_valid", 32'(bus.uop_valid), 0);
                    chk("flush_last", 32'(bus.uop_last), 0);
                    chk("flush_busy", 32'(bus.busy), 0);
                    break;
                end
                if (stall) stl++;
                else issued++;
                if (cyc == 39) chk("seq_timeout", 1, 0);
            end
        end

        idle_inputs();
        @(negedge clk);
        chk("tail_stall_up", 32'(bus.stall_up), 0);
        @(posedge clk); #1;
        chk("tail_valid", 32'(bus.uop_valid), 0);
        chk("tail_busy", 32'(bus.busy), 0);
`ifdef LMSM_ZERO_LIST_TRAP_EN
        chk("tail_illegal", 32'(bus.illegal_list), 0);
`endif
    endtask

    initial begin
        logic [7:0]  rl;
        logic [15:0] rb;
        int          rn;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        #12;
        chk("rst_valid", 32'(bus.uop_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_stall_up", 32'(bus.stall_up), 0);
        chk("rst_last", 32'(bus.uop_last), 0);
        chk("rst_addr", 32'(bus.uop_addr), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(1'b1, 8'hA4, 16'h0100, -1, 0, -1);
        run(1'b0, 8'h08, 16'h2000, -1, 0, -1);
        run(1'b1, 8'hFF, 16'hFFFE, 2, 2, -1);
        run(1'b0, 8'h0F, 16'h0040, -1, 0, 2);
        run(1'b1, 8'h00, 16'h0300, -1, 0, -1);
        run(1'b0, 8'h81, 16'h0500, -1, 0, 0);

        // asynchronous reset in the middle of a sequence
        bus.valid_rr  = 1'b1;
        bus.is_lm_rr  = 1'b1;
        bus.list_rr   = 8'hF0;
        bus.base_addr = 16'h0700;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(bus.busy), 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.uop_valid), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_stall_up", 32'(bus.stall_up), 0);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        run(1'b1, 8'h01, 16'h1234, -1, 0, -1);

        for (int k = 0; k < 40; k++) begin
            rl = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rl = 8'h00;
            rb = 16'($urandom);
            rn = $countones(rl);
            run(1'($urandom_range(0, 1)), rl, rb,
                $urandom_range(1, 8), $urandom_range(1, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
